adc_trig_capture: RTL and testbench

ADC_TRIG_CAPTURE -- requirements
Module: adc_trig_capture

---
 rtl/adc_trig_capture.sv | 140 ++++++++++++++
 tb/tb_adc_trig_capture.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/adc_trig_capture.sv
// Triggered ADC capture: waits for a level crossing, records 2**DEPTH_LOG2 consecutive samples,
// then streams them out over a valid/ready port. Define ADC_CAPTURE_AUTOTRIG_EN for auto-trigger.
module adc_trig_capture #(
    parameter int unsigned DEPTH_LOG2     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] adc_d,
    input  logic       arm,
    input  logic [7:0] trig_level,
    input  logic       trig_rise,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       triggered
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LastAddr = DEPTH_LOG2'(Depth - 1);

    typedef enum logic [1:0] {StIdle, StWaitTrig, StCapture, StDump} state_e;

    state_e state_q, state_d;

    logic [7:0]            cur_q, prev_q;
    logic                  prev_ok_q;
    logic [DEPTH_LOG2-1:0] wr_addr_q, rd_addr_q;
    logic                  rd_last_q;
    logic [7:0]            tx_data_q;
    logic                  tx_valid_q;
    logic                  triggered_q;
    logic [7:0]            mem [Depth];

    logic start, crossing, timeout, fire, wr_en, cap_done, load, dump_done;

    assign start    = (state_q == StIdle) && arm;
    assign crossing = prev_ok_q && (trig_rise ? (prev_q < trig_level && cur_q >= trig_level)
                                              : (prev_q >= trig_level && cur_q < trig_level));
    assign fire     = (state_q == StWaitTrig) && (crossing || timeout);
    assign wr_en    = fire || (state_q == StCapture);
    assign cap_done = (state_q == StCapture) && (wr_addr_q == LastAddr);
    assign load     = (state_q == StDump) && !rd_last_q && (!tx_valid_q || tx_ready);
    assign dump_done = (state_q == StDump) && rd_last_q && tx_valid_q && tx_ready;

`ifdef ADC_CAPTURE_AUTOTRIG_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
    logic [ToW-1:0] to_cnt_q;

    assign timeout = (state_q == StWaitTrig) && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else if ((state_q == StWaitTrig) && !fire) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end else begin
            to_cnt_q <= '0;
        end
    end
`else
    logic unused_timeout_cycles;
    assign timeout = 1'b0;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (arm)       state_d = StWaitTrig;
            StWaitTrig: if (fire)      state_d = StCapture;
            StCapture:  if (cap_done)  state_d = StDump;
            StDump:     if (dump_done) state_d = StIdle;
            default:                   state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        tx_data   = tx_data_q;
        tx_valid  = tx_valid_q;
        triggered = triggered_q;
    end

    // Write address is always 0 in WAIT_TRIG (reset or wrap), so the trigger sample lands at 0.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr_q] <= cur_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q       <= '0;
            prev_q      <= '0;
            prev_ok_q   <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            rd_last_q   <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            cur_q     <= adc_d;
            prev_q    <= cur_q;
            prev_ok_q <= !start;

            if (start) begin
                triggered_q <= 1'b0;
            end else if (fire && crossing) begin
                triggered_q <= 1'b1;
            end

            if (wr_en) begin
                wr_addr_q <= wr_addr_q + 1'b1;
            end

            // tx_data_q doubles as the synchronous memory read register.
            if (load) begin
                tx_data_q  <= mem[rd_addr_q];
                tx_valid_q <= 1'b1;
                rd_addr_q  <= rd_addr_q + 1'b1;
                rd_last_q  <= (rd_addr_q == LastAddr);
            end else if (dump_done) begin
                tx_valid_q <= 1'b0;
                rd_last_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_trig_capture.sv
// Directed bench for adc_trig_capture (DEPTH_LOG2=4, TIMEOUT_CYCLES=100).
// Auto-trigger checks follow ADC_CAPTURE_AUTOTRIG_EN, matching the DUT build.
module tb_adc_trig_capture;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] adc_d;
    logic       arm;
    logic [7:0] trig_level;
    logic       trig_rise;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       triggered;

    int n_vec = 0;
    int n_err = 0;
    int dump_cycles;
    logic [7:0] exp_q [16];

    adc_trig_capture #(
        .DEPTH_LOG2    (4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .adc_d     (adc_d),
        .arm       (arm),
        .trig_level(trig_level),
        .trig_rise (trig_rise),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .triggered (triggered)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One posedge per step; adc_d = start + i*step, arm pulsed on the listed steps.
    task automatic feed(input logic [7:0] start, input logic [7:0] step, input int n,
                        input int arm_a, input int arm_b);
        for (int i = 0; i < n; i++) begin
            adc_d = start + 8'(i) * step;
            arm   = (i == arm_a) || (i == arm_b);
            @(negedge clk);
        end
        arm = 1'b0;
    endtask

    // Drains 16 bytes against exp_q; toggle selects ready pattern 1,0,0,1,0,0...
    task automatic dump_expect(input string tag, input bit toggle);
        int   got;
        int   cyc;
        logic [7:0] held;
        bit   stalled;
        got     = 0;
        cyc     = 0;
        held    = '0;
        stalled = 1'b0;
        while (cyc < 200 && got < 16) begin
            tx_ready = toggle ? ((cyc % 3) == 0) : 1'b1;
            if (stalled) begin
                check({tag, "_hold_v"}, tx_valid, 1);
                check({tag, "_hold_d"}, tx_data, held);
            end
            stalled = 1'b0;
            if (tx_valid) begin
                if (tx_ready) begin
                    check({tag, "_data"}, tx_data, exp_q[got]);
                    got++;
                end else begin
                    held    = tx_data;
                    stalled = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        tx_ready    = 1'b0;
        dump_cycles = cyc;
        check({tag, "_count"}, got, 16);
        check({tag, "_valid_end"}, tx_valid, 0);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        reset      = 1'b1;
        adc_d      = '0;
        arm        = 1'b0;
        trig_level = 8'h80;
        trig_rise  = 1'b1;
        tx_ready   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", tx_valid, 0);
        check("rst_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_trig", triggered, 0);
        reset = 1'b0;
        @(negedge clk);

        // Rising ramp through 0x80, stalled readout.
        feed(8'h70, 8'd1, 40, 0, -1);
        check("ramp_busy", busy, 1);
        check("ramp_trig", triggered, 1);
        check("ramp_first_v", tx_valid, 1);
        check("ramp_first_d", tx_data, 8'h80);
        for (int i = 0; i < 16; i++) exp_q[i] = 8'h80 + 8'(i);
        dump_expect("ramp", 1'b1);

        // Falling step 0x50 -> 0x3F across 0x40, full-rate readout.
        trig_rise  = 1'b0;
        trig_level = 8'h40;
        feed(8'h50, 8'd0, 3, 0, -1);
        feed(8'h3F, 8'd0, 30, -1, -1);
        check("fall_trig", triggered, 1);
        for (int i = 0; i < 16; i++) exp_q[i] = 8'h3F;
        dump_expect("fall", 1'b0);
        check("fall_no_gaps", dump_cycles <= 32, 1);

        // Stray ARM during CAPTURE must be ignored.
        trig_rise  = 1'b1;
        trig_level = 8'h80;
        feed(8'h70, 8'd1, 40, 0, 20);
        for (int i = 0; i < 16; i++) exp_q[i] = 8'h80 + 8'(i);
        dump_expect("arm_cap", 1'b0);
        repeat (30) @(negedge clk);
        check("arm_cap_idle_busy", busy, 0);
        check("arm_cap_idle_v", tx_valid, 0);

        // Reset while write address is 5.
        feed(8'h70, 8'd1, 22, 0, -1);
        check("rstmid_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_valid", tx_valid, 0);
        check("rstmid_trig", triggered, 0);
        @(negedge clk);
        reset    = 1'b0;
        tx_ready = 1'b1;
        begin
            bit saw_valid;
            saw_valid = 1'b0;
            for (int i = 0; i < 40; i++) begin
                adc_d = 8'h70 + 8'(i);
                @(negedge clk);
                if (tx_valid) saw_valid = 1'b1;
            end
            check("rstmid_no_valid", saw_valid, 0);
        end
        tx_ready = 1'b0;
        check("rstmid_idle", busy, 0);

        // Constant input: only the auto-trigger can start a capture.
        trig_rise  = 1'b1;
        trig_level = 8'h80;
`ifdef ADC_CAPTURE_AUTOTRIG_EN
        feed(8'h10, 8'd0, 116, 0, -1);
        check("auto_valid_early", tx_valid, 0);
        feed(8'h10, 8'd0, 1, -1, -1);
        check("auto_valid_on_time", tx_valid, 1);
        check("auto_trig", triggered, 0);
        for (int i = 0; i < 16; i++) exp_q[i] = 8'h10;
        dump_expect("auto", 1'b0);
`else
        feed(8'h10, 8'd0, 300, 0, -1);
        check("noauto_busy", busy, 1);
        check("noauto_valid", tx_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("noauto_reset_idle", busy, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
